vrf_addr_sequencer: RTL and testbench

Per-instruction address sequencer for the vector register file (VRF). It accepts the eight per-register starting addresses for vs1, vs2 and vd produced by the register-mapping stage. It then walks them word by word across the LMUL register group, emitting one read-address pair per cycle and a write-address stream that trails it by a fixed lane-pipeline latency. It sits between the vector control unit's issue logic and the VRF port muxes, and honours a global stall.

---
 rtl/vrf_addr_sequencer_if.sv | 37 +++
 rtl/vrf_addr_sequencer.sv | 155 +++++++++++++++
 tb/tb_vrf_addr_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vrf_addr_sequencer_if.sv
// Issue-side request signals and VRF-port-side address streams of the VRF address sequencer.
interface vrf_addr_sequencer_if #(
  parameter int VLEN      = 4096,
  parameter int VLANE_NUM = 8
);
  localparam int MEM_DEPTH = VLEN / VLANE_NUM;
  localparam int AW        = $clog2(MEM_DEPTH);
  localparam int REG_WORDS = VLEN / 32 / VLANE_NUM;
  localparam int CW        = $clog2(8 * REG_WORDS) + 1;

  logic              start_vld_i;
  logic              start_rdy_o;
  logic [8*AW-1:0]   base_raddr0_i;
  logic [8*AW-1:0]   base_raddr1_i;
  logic [8*AW-1:0]   base_waddr_i;
  logic [1:0]        lmul_i;
  logic [CW-1:0]     vl_words_i;
  logic              stall_i;
  logic [AW-1:0]     raddr0_o;
  logic [AW-1:0]     raddr1_o;
  logic              rd_vld_o;
  logic [AW-1:0]     waddr_o;
  logic              wr_vld_o;
  logic              done_o;

  modport master (
    output start_vld_i, base_raddr0_i, base_raddr1_i, base_waddr_i,
           lmul_i, vl_words_i, stall_i,
    input  start_rdy_o, raddr0_o, raddr1_o, rd_vld_o, waddr_o, wr_vld_o, done_o
  );

  modport slave (
    input  start_vld_i, base_raddr0_i, base_raddr1_i, base_waddr_i,
           lmul_i, vl_words_i, stall_i,
    output start_rdy_o, raddr0_o, raddr1_o, rd_vld_o, waddr_o, wr_vld_o, done_o
  );
endinterface

// File: rtl/vrf_addr_sequencer.sv
// Walks the vs1/vs2/vd register groups word by word, issuing read addresses and a
// write-address stream that trails the reads by the lane-pipeline latency.
module vrf_addr_sequencer #(
  parameter int VLEN       = 4096,
  parameter int VLANE_NUM  = 8,
  parameter int W_PIPE_LAT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  vrf_addr_sequencer_if.slave  bus
);
  localparam int MEM_DEPTH = VLEN / VLANE_NUM;
  localparam int AW        = $clog2(MEM_DEPTH);
  localparam int REG_WORDS = VLEN / 32 / VLANE_NUM;
  localparam int CW        = $clog2(8 * REG_WORDS) + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t              r_state, w_stateNext;
  logic [8*AW-1:0]     r_base0, r_base1, r_baseW;
  logic [8*AW-1:0]     w_base0Next, w_base1Next, w_baseWNext;
  logic [CW-1:0]       r_vle, w_vleNext;
  logic [CW-1:0]       r_rcnt, w_rcntNext;
  logic [CW-1:0]       r_wcnt, w_wcntNext;
  logic [W_PIPE_LAT-1:0] r_vpipe, w_pipeNext;
  logic [AW-1:0]       r_raddr0, r_raddr1, r_waddr;
  logic [AW-1:0]       w_raddr0Next, w_raddr1Next, w_waddrNext;
  logic                r_rdVld, r_wrVld, r_done;
  logic                w_rdVldNext, w_wrVldNext, w_doneNext;
  logic                w_rdIssue, w_wrIssue;
  logic [CW-1:0]       w_maxWords, w_vleIn;

  // Each register slot is an independent pointer; the offset wraps modulo MEM_DEPTH.
  function automatic logic [AW-1:0] slotAddr(input logic [8*AW-1:0] bases,
                                             input logic [CW-1:0]   word);
    logic [2:0]    slot;
    logic [AW-1:0] off;
    logic [AW-1:0] base;
    slot = 3'(word / CW'(REG_WORDS));
    off  = AW'(word % CW'(REG_WORDS));
    base = '0;
    for (int k = 0; k < 8; k++) begin
      if (slot == 3'(k)) base = bases[k*AW +: AW];
    end
    return base + off;
  endfunction

  assign w_maxWords = CW'(REG_WORDS) << bus.lmul_i;
  assign w_vleIn    = (bus.vl_words_i < w_maxWords) ? bus.vl_words_i : w_maxWords;

  assign bus.start_rdy_o = (r_state == IDLE);
  assign bus.raddr0_o    = r_raddr0;
  assign bus.raddr1_o    = r_raddr1;
  assign bus.rd_vld_o    = r_rdVld;
  assign bus.waddr_o     = r_waddr;
  assign bus.wr_vld_o    = r_wrVld;
  assign bus.done_o      = r_done;

  // Next-state and datapath decode; a handshake is taken even while stalled.
  always_comb begin
    w_stateNext  = r_state;
    w_base0Next  = r_base0;
    w_base1Next  = r_base1;
    w_baseWNext  = r_baseW;
    w_vleNext    = r_vle;
    w_rcntNext   = r_rcnt;
    w_wcntNext   = r_wcnt;
    w_pipeNext   = r_vpipe;
    w_raddr0Next = r_raddr0;
    w_raddr1Next = r_raddr1;
    w_waddrNext  = r_waddr;
    w_rdVldNext  = 1'b0;
    w_wrVldNext  = 1'b0;
    w_doneNext   = 1'b0;
    w_rdIssue    = 1'b0;
    w_wrIssue    = 1'b0;

    if (r_state == IDLE && bus.start_vld_i) begin
      w_base0Next = bus.base_raddr0_i;
      w_base1Next = bus.base_raddr1_i;
      w_baseWNext = bus.base_waddr_i;
      w_vleNext   = w_vleIn;
      w_rcntNext  = '0;
      w_wcntNext  = '0;
      w_pipeNext  = '0;
      w_stateNext = (w_vleIn == '0) ? DONE : READ;
    end else if (!bus.stall_i) begin
      w_rdIssue     = (r_state == READ);
      w_wrIssue     = r_vpipe[W_PIPE_LAT-1];
      w_pipeNext    = r_vpipe << 1;
      w_pipeNext[0] = w_rdIssue;

      if (w_rdIssue) begin
        w_rdVldNext  = 1'b1;
        w_raddr0Next = slotAddr(r_base0, r_rcnt);
        w_raddr1Next = slotAddr(r_base1, r_rcnt);
        w_rcntNext   = r_rcnt + CW'(1);
        if (r_rcnt == r_vle - CW'(1)) w_stateNext = DRAIN;
      end

      // The last write always lands in DRAIN, so it alone closes the instruction.
      if (w_wrIssue) begin
        w_wrVldNext = 1'b1;
        w_waddrNext = slotAddr(r_baseW, r_wcnt);
        w_wcntNext  = r_wcnt + CW'(1);
        if (r_wcnt == r_vle - CW'(1)) begin
          w_doneNext  = 1'b1;
          w_stateNext = IDLE;
        end
      end

      if (r_state == DONE) begin
        w_doneNext  = 1'b1;
        w_stateNext = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_stateNext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base0  <= '0;
      r_base1  <= '0;
      r_baseW  <= '0;
      r_vle    <= '0;
      r_rcnt   <= '0;
      r_wcnt   <= '0;
      r_vpipe  <= '0;
      r_raddr0 <= '0;
      r_raddr1 <= '0;
      r_waddr  <= '0;
      r_rdVld  <= 1'b0;
      r_wrVld  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_base0  <= w_base0Next;
      r_base1  <= w_base1Next;
      r_baseW  <= w_baseWNext;
      r_vle    <= w_vleNext;
      r_rcnt   <= w_rcntNext;
      r_wcnt   <= w_wcntNext;
      r_vpipe  <= w_pipeNext;
      r_raddr0 <= w_raddr0Next;
      r_raddr1 <= w_raddr1Next;
      r_waddr  <= w_waddrNext;
      r_rdVld  <= w_rdVldNext;
      r_wrVld  <= w_wrVldNext;
      r_done   <= w_doneNext;
    end
  end
endmodule

// File: tb/tb_vrf_addr_sequencer.sv
// Self-checking bench for vrf_addr_sequencer: directed vector table, reset abort,
// and randomized instructions with random stalls against a word-count reference model.
module tb_vrf_addr_sequencer;
  localparam int VLEN       = 4096;
  localparam int VLANE_NUM  = 8;
  localparam int W_PIPE_LAT = 4;
  localparam int MEM_DEPTH  = VLEN / VLANE_NUM;
  localparam int AW         = $clog2(MEM_DEPTH);
  localparam int REG_WORDS  = VLEN / 32 / VLANE_NUM;
  localparam int CW         = $clog2(8 * REG_WORDS) + 1;
  localparam int MAX_CYC    = 600;

  typedef struct {
    string name;
    int lmul, vl, b0, b1, bw, stride, stallFrom, stallLen;
    int expReads, expWrites, expDone, expFR0, expLR0, expFW, expLW;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  vrf_addr_sequencer_if #(.VLEN(VLEN), .VLANE_NUM(VLANE_NUM)) bus();

  vrf_addr_sequencer #(.VLEN(VLEN), .VLANE_NUM(VLANE_NUM), .W_PIPE_LAT(W_PIPE_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int bases0[8], bases1[8], basesW[8];
  bit stallPlan[0:MAX_CYC];
  int lastR0, lastR1, lastW;
  int tReads, tWrites, tDone, tFR0, tLR0, tFW, tLW;
  vec_t vecs[8];

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic int addrOf(input int b[8], input int w);
    return (b[w / REG_WORDS] + w % REG_WORDS) % MEM_DEPTH;
  endfunction

  function automatic logic [8*AW-1:0] packBases(input int b[8]);
    logic [8*AW-1:0] p;
    for (int k = 0; k < 8; k++) p[k*AW +: AW] = AW'(b[k]);
    return p;
  endfunction

  task automatic setBases(input int b0, input int b1, input int bw, input int stride);
    for (int k = 0; k < 8; k++) begin
      bases0[k] = (b0 + k * stride) % MEM_DEPTH;
      bases1[k] = (b1 + k * stride) % MEM_DEPTH;
      basesW[k] = (bw + k * stride) % MEM_DEPTH;
    end
  endtask

  // Runs one instruction from handshake to done; called just after a falling edge.
  task automatic applyStimulus(input string name, input int lmul, input int vl);
    int vle, ns, k, expRd, expWr, expDn;
    bit doneSeen;
    vle = (vl < (REG_WORDS << lmul)) ? vl : (REG_WORDS << lmul);
    ns = 0; k = 0; doneSeen = 0;
    tReads = 0; tWrites = 0; tDone = -1; tFR0 = -1; tLR0 = -1; tFW = -1; tLW = -1;

    checkOutput({name, " ready"}, int'(bus.start_rdy_o), 1);
    bus.start_vld_i   = 1'b1;
    bus.base_raddr0_i = packBases(bases0);
    bus.base_raddr1_i = packBases(bases1);
    bus.base_waddr_i  = packBases(basesW);
    bus.lmul_i        = 2'(lmul);
    bus.vl_words_i    = CW'(vl);
    bus.stall_i       = stallPlan[0];
    @(posedge clk);
    @(negedge clk);

    while (!doneSeen && k < MAX_CYC) begin
      k++;
      bus.stall_i       = stallPlan[k];
      bus.start_vld_i   = 1'($urandom);
      bus.base_raddr0_i = (8*AW)'({$urandom(), $urandom(), $urandom()});
      bus.base_waddr_i  = (8*AW)'({$urandom(), $urandom(), $urandom()});
      bus.lmul_i        = 2'($urandom);
      bus.vl_words_i    = CW'($urandom);
      @(posedge clk);
      @(negedge clk);

      expRd = 0; expWr = 0; expDn = 0;
      if (!stallPlan[k]) begin
        ns++;
        if (ns <= vle) begin
          expRd  = 1;
          lastR0 = addrOf(bases0, ns - 1);
          lastR1 = addrOf(bases1, ns - 1);
        end
        if (vle > 0 && ns > W_PIPE_LAT && ns <= vle + W_PIPE_LAT) begin
          expWr = 1;
          lastW = addrOf(basesW, ns - W_PIPE_LAT - 1);
        end
        if ((vle == 0 && ns == 1) || (vle > 0 && ns == vle + W_PIPE_LAT)) expDn = 1;
      end
      if (expDn == 1) doneSeen = 1;

      checkOutput($sformatf("%s c%0d rd_vld", name, k), int'(bus.rd_vld_o), expRd);
      checkOutput($sformatf("%s c%0d wr_vld", name, k), int'(bus.wr_vld_o), expWr);
      checkOutput($sformatf("%s c%0d done", name, k), int'(bus.done_o), expDn);
      checkOutput($sformatf("%s c%0d raddr0", name, k), int'(bus.raddr0_o), lastR0);
      checkOutput($sformatf("%s c%0d raddr1", name, k), int'(bus.raddr1_o), lastR1);
      checkOutput($sformatf("%s c%0d waddr", name, k), int'(bus.waddr_o), lastW);
      checkOutput($sformatf("%s c%0d rdy", name, k), int'(bus.start_rdy_o), int'(doneSeen));

      if (bus.rd_vld_o) begin
        tReads++;
        if (tFR0 < 0) tFR0 = int'(bus.raddr0_o);
        tLR0 = int'(bus.raddr0_o);
      end
      if (bus.wr_vld_o) begin
        tWrites++;
        if (tFW < 0) tFW = int'(bus.waddr_o);
        tLW = int'(bus.waddr_o);
      end
      if (bus.done_o && tDone < 0) tDone = k;
    end
    if (!doneSeen) checkOutput({name, " completion within budget"}, 0, 1);
    bus.start_vld_i = 1'b0;
    bus.stall_i     = 1'b0;
  endtask

  task automatic resetMidOp();
    int seenDone, seenVld;
    setBases(48, 96, 160, 0);
    bus.start_vld_i   = 1'b1;
    bus.base_raddr0_i = packBases(bases0);
    bus.base_raddr1_i = packBases(bases1);
    bus.base_waddr_i  = packBases(basesW);
    bus.lmul_i        = 2'd0;
    bus.vl_words_i    = CW'(16);
    bus.stall_i       = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start_vld_i = 1'b0;
    repeat (7) begin
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("rst pre rd_vld", int'(bus.rd_vld_o), 1);
    checkOutput("rst pre wr_vld", int'(bus.wr_vld_o), 1);
    rst = 1'b1;
    #1;
    checkOutput("rst rd_vld", int'(bus.rd_vld_o), 0);
    checkOutput("rst wr_vld", int'(bus.wr_vld_o), 0);
    checkOutput("rst done", int'(bus.done_o), 0);
    checkOutput("rst raddr0", int'(bus.raddr0_o), 0);
    checkOutput("rst raddr1", int'(bus.raddr1_o), 0);
    checkOutput("rst waddr", int'(bus.waddr_o), 0);
    checkOutput("rst rdy", int'(bus.start_rdy_o), 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seenDone = 0;
    seenVld  = 0;
    repeat (30) begin
      @(posedge clk);
      @(negedge clk);
      seenDone += int'(bus.done_o);
      seenVld  += int'(bus.rd_vld_o) + int'(bus.wr_vld_o);
    end
    checkOutput("rst no done after abort", seenDone, 0);
    checkOutput("rst no valids after abort", seenVld, 0);
    lastR0 = 0; lastR1 = 0; lastW = 0;
    for (int i = 0; i <= MAX_CYC; i++) stallPlan[i] = 1'b0;
    applyStimulus("post-rst", 0, 16);
    checkOutput("post-rst reads", tReads, 16);
    checkOutput("post-rst writes", tWrites, 16);
    checkOutput("post-rst done cycle", tDone, 20);
  endtask

  initial begin
    vecs[0] = '{"single",   0, 16,  48,  96, 160,   0, 0, 0, 16, 16, 20,  48,  63, 160, 175};
    vecs[1] = '{"boundary", 1, 20,  32, 300,  64, 136, 0, 0, 20, 20, 24,  32, 171,  64, 203};
    vecs[2] = '{"stall",    0, 16,  48,  96, 160,   0, 3, 3, 16, 16, 23,  48,  63, 160, 175};
    vecs[3] = '{"clamp",    0, 40,  48,  96, 160,   0, 0, 0, 16, 16, 20,  48,  63, 160, 175};
    vecs[4] = '{"zero",     2,  0,  48,  96, 160,   0, 0, 0,  0,  0,  1,  -1,  -1,  -1,  -1};
    vecs[5] = '{"wrap",     0,  4, 510,   5, 509,   0, 0, 0,  4,  4,  8, 510,   1, 509,   0};
    vecs[6] = '{"full8",    3,128,   0, 100,   0,  64, 0, 0,128,128,132,   0, 463,   0, 463};
    vecs[7] = '{"clamp4",   2,200,  10,  20,  30,  50, 0, 0, 64, 64, 68,  10, 175,  30, 195};

    rst = 1'b1;
    bus.start_vld_i   = 1'b0;
    bus.base_raddr0_i = '0;
    bus.base_raddr1_i = '0;
    bus.base_waddr_i  = '0;
    bus.lmul_i        = 2'd0;
    bus.vl_words_i    = '0;
    bus.stall_i       = 1'b0;
    #1;
    checkOutput("reset rdy", int'(bus.start_rdy_o), 1);
    checkOutput("reset rd_vld", int'(bus.rd_vld_o), 0);
    checkOutput("reset wr_vld", int'(bus.wr_vld_o), 0);
    checkOutput("reset done", int'(bus.done_o), 0);
    checkOutput("reset raddr0", int'(bus.raddr0_o), 0);
    checkOutput("reset raddr1", int'(bus.raddr1_o), 0);
    checkOutput("reset waddr", int'(bus.waddr_o), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lastR0 = 0; lastR1 = 0; lastW = 0;

    $display("[TB] directed vector table");
    for (int v = 0; v < 8; v++) begin
      setBases(vecs[v].b0, vecs[v].b1, vecs[v].bw, vecs[v].stride);
      for (int i = 0; i <= MAX_CYC; i++) stallPlan[i] = 1'b0;
      for (int i = 0; i < vecs[v].stallLen; i++) stallPlan[vecs[v].stallFrom + i] = 1'b1;
      applyStimulus(vecs[v].name, vecs[v].lmul, vecs[v].vl);
      checkOutput({vecs[v].name, " reads"}, tReads, vecs[v].expReads);
      checkOutput({vecs[v].name, " writes"}, tWrites, vecs[v].expWrites);
      checkOutput({vecs[v].name, " done cycle"}, tDone, vecs[v].expDone);
      checkOutput({vecs[v].name, " first raddr0"}, tFR0, vecs[v].expFR0);
      checkOutput({vecs[v].name, " last raddr0"}, tLR0, vecs[v].expLR0);
      checkOutput({vecs[v].name, " first waddr"}, tFW, vecs[v].expFW);
      checkOutput({vecs[v].name, " last waddr"}, tLW, vecs[v].expLW);
    end

    $display("[TB] reset during an instruction");
    resetMidOp();

    $display("[TB] randomized instructions with random stalls");
    for (int t = 0; t < 25; t++) begin
      for (int k = 0; k < 8; k++) begin
        bases0[k] = int'($urandom_range(0, MEM_DEPTH - 1));
        bases1[k] = int'($urandom_range(0, MEM_DEPTH - 1));
        basesW[k] = int'($urandom_range(0, MEM_DEPTH - 1));
      end
      for (int i = 0; i <= MAX_CYC; i++)
        stallPlan[i] = (i <= 300) ? ($urandom_range(0, 4) == 0) : 1'b0;
      applyStimulus($sformatf("rand%0d", t), int'($urandom_range(0, 3)),
                    (t % 5 == 4) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 140)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
